vec_insn_decode_q: RTL
======================

Name: vec_insn_decode_q

Overview:
- Next-generation RVV instruction decoder with a valid/ready handshake and a parametrised output queue. It replaces a fixed one-register field slicer.
- Accepts one 32-bit instruction per cycle from fetch and classifies it as CFG, ALU, LOAD, STORE or ILLEGAL.
- Extracts all RVV fields and buffers the decoded record in a DEPTH-entry FIFO ahead of the vector issue stage.
- Supports flush for redirects and keeps saturating decode/illegal counters.

Parameters:
- INSN_WIDTH, 32, instruction width; must be 32. Elaboration error otherwise.
- DEPTH, 2, decoded-record queue entries; must be 2..16, power of two.
- CNT_WIDTH, 16, width of each status counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  drop all queued records.
- in_valid  in  1  insn_in is valid.
- in_ready  out  1  decoder can accept.
- insn_in  in  INSN_WIDTH  raw instruction.
- out_valid  out  1  head record is valid.
- out_ready  in  1  consumer takes the head record.
- out_class  out  3  insn_class_e: CFG=0, ALU=1, LOAD=2, STORE=3, ILLEGAL=7.
- out_funct3  out  3  bits [14:12]; also the ALU type or the mem width.
- out_dest  out  5  bits [11:7]: rd, vd or vs3.
- out_src_1  out  5  bits [19:15]: rs1, vs1 or imm.
- out_src_2  out  5  bits [24:20]: rs2, vs2 or lumop/sumop.
- out_vm  out  1  bit [25].
- out_funct6  out  6  bits [31:26].
- out_mop  out  2  bits [27:26].
- out_mew  out  1  bit [28].
- out_nf  out  3  bits [31:29].
- out_zimm_11  out  11  bits [30:20].
- out_zimm_10  out  10  bits [29:20].
- out_cfg_type  out  2  cfg_type_e: VSETVLI=0 (bit31=0), VSETVL=2 (bits[31:30]=10), VSETIVLI=3 (bits[31:30]=11).
- decode_cnt  out  CNT_WIDTH  saturating count of accepted instructions.
- illegal_cnt  out  CNT_WIDTH  saturating count of accepted ILLEGAL instructions.

Behaviour:
- Reset (rst=0, asynchronous): FIFO count, read pointer and write pointer = 0. All storage entries = 0. out_valid=0. All out_* = 0. Both counters = 0. in_ready=1 once reset is released.
- Classification (combinational on insn_in):
  - opcode 1010111 with funct3=111 -> CFG.
  - opcode 1010111 with any other funct3 -> ALU.
  - opcode 0000111 with width in {000,101,110,111} and mew=0 -> LOAD.
  - opcode 0100111 with width in {000,101,110,111} and mew=0 -> STORE.
  - Everything else -> ILLEGAL. This includes scalar FP widths 001–100 and mew=1.
  - out_cfg_type is computed for every class; consumers use it only when class=CFG.
- Handshake:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - in_ready = (count < DEPTH). It is registered-state-only; there is no combinational path from out_ready.
  - out_valid = (count != 0). out_* always reflect the head entry.
- Latency: a record pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no same-cycle bypass.
- Throughput: with DEPTH>=2 and out_ready held high, one record per cycle is sustained.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_ready=0 and insn_in is ignored. Pop while full: in_ready rises the next cycle.
- Empty: out_ready is ignored and out_* hold the last head contents (do not care).
- Pointers wrap modulo DEPTH.
- Flush: has priority over push and pop in the same cycle. Next state: count=0, pointers=0. Storage is not cleared. Counters are not incremented by a push coincident with flush.
- Counters increment on push. illegal_cnt increments only when class=ILLEGAL. Both saturate at all-ones and never wrap.
- Reset mid-stream: all queued records are lost immediately and out_valid drops asynchronously.

Decomposition:
- Package vec_decode_pkg holds:
  - Opcode constants: OPC_OPV=7'b1010111, OPC_LOADFP=7'b0000111, OPC_STOREFP=7'b0100111, F3_CFG=3'b111.
  - Legal vector width constants.
  - insn_class_e and cfg_type_e.
  - packed struct vdec_rec_t holding all out_* fields.
- Sub-module vec_insn_classify: purely combinational, insn_in -> vdec_rec_t.
- The top level holds the FIFO, handshake, flush and counters.

Test Plan:
- Basic ALU: reset, then drive 0x022180D7 (vadd.vv v1,v2,v3) for one cycle with out_ready=1 -> next cycle out_valid=1, class=ALU, dest=1, src_1=3, src_2=2, vm=1, funct3=0, funct6=0; decode_cnt=1.
- CFG: 0x010572D7 (vsetvli x5,x10,e32,m1) -> class=CFG, dest=5, src_1=10, zimm_11=0x010, cfg_type=VSETVLI.
- LOAD and ILLEGAL: 0x0200E207 (vle32.v v4,(x1)) -> class=LOAD, funct3=110, mop=0, vm=1, dest=4. Then 0x0000A007 (flw) and 0x00000013 -> class=ILLEGAL each; illegal_cnt=2.
- Backpressure, DEPTH=2: out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts and the third is held. Raise out_ready -> records drain in order, the third is accepted the cycle after the first pop, and no loss or duplication occurs.
- Flush: fill 2 entries, assert flush together with in_valid=1 -> next cycle out_valid=0, count=0, and decode_cnt is unchanged by the flushed-cycle push.
- Saturation: with CNT_WIDTH=4, push 20 ILLEGAL instructions -> decode_cnt=illegal_cnt=15. Async reset asserted mid-stream -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/vec_decode_pkg.sv
// Shared opcode constants, class/config enums and the decoded-record layout
// for the RVV instruction decoder and its output queue.
package vec_decode_pkg;

   localparam int INSN_W = 32;

   localparam logic [6:0] OPC_OPV     = 7'b1010111;
   localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
   localparam logic [6:0] OPC_STOREFP = 7'b0100111;
   localparam logic [2:0] F3_CFG      = 3'b111;

   localparam logic [2:0] VW_E8  = 3'b000;
   localparam logic [2:0] VW_E16 = 3'b101;
   localparam logic [2:0] VW_E32 = 3'b110;
   localparam logic [2:0] VW_E64 = 3'b111;

   typedef enum logic [2:0] {
      CLS_CFG     = 3'd0,
      CLS_ALU     = 3'd1,
      CLS_LOAD    = 3'd2,
      CLS_STORE   = 3'd3,
      CLS_ILLEGAL = 3'd7
   } insn_class_e;

   typedef enum logic [1:0] {
      CFG_VSETVLI  = 2'd0,
      CFG_VSETVL   = 2'd2,
      CFG_VSETIVLI = 2'd3
   } cfg_type_e;

   typedef struct packed {
      insn_class_e cls;
      logic [2:0]  funct3;
      logic [4:0]  dest;
      logic [4:0]  src_1;
      logic [4:0]  src_2;
      logic        vm;
      logic [5:0]  funct6;
      logic [1:0]  mop;
      logic        mew;
      logic [2:0]  nf;
      logic [10:0] zimm_11;
      logic [9:0]  zimm_10;
      cfg_type_e   cfg_type;
   } vdec_rec_t;

   // Scalar FP widths 001..100 share the load/store opcodes but are not vector.
   function automatic logic is_vec_width(input logic [2:0] w);
      return (w == VW_E8) || (w == VW_E16) || (w == VW_E32) || (w == VW_E64);
   endfunction

endpackage

// File: rtl/vec_insn_classify.sv
// Combinational RVV field slicer and instruction classifier.
module vec_insn_classify
   import vec_decode_pkg::*;
(
   input  logic [INSN_W-1:0] insn_i,
   output vdec_rec_t         rec_o
);

   logic [6:0] opcode;
   logic [2:0] width;
   logic       mem_ok;

   assign opcode = insn_i[6:0];
   assign width  = insn_i[14:12];
   assign mem_ok = is_vec_width(width) && !insn_i[28];

   always_comb begin
      rec_o          = '0;
      rec_o.funct3   = insn_i[14:12];
      rec_o.dest     = insn_i[11:7];
      rec_o.src_1    = insn_i[19:15];
      rec_o.src_2    = insn_i[24:20];
      rec_o.vm       = insn_i[25];
      rec_o.funct6   = insn_i[31:26];
      rec_o.mop      = insn_i[27:26];
      rec_o.mew      = insn_i[28];
      rec_o.nf       = insn_i[31:29];
      rec_o.zimm_11  = insn_i[30:20];
      rec_o.zimm_10  = insn_i[29:20];

      if (opcode == OPC_OPV) begin
         rec_o.cls = (width == F3_CFG) ? CLS_CFG : CLS_ALU;
      end else if (opcode == OPC_LOADFP && mem_ok) begin
         rec_o.cls = CLS_LOAD;
      end else if (opcode == OPC_STOREFP && mem_ok) begin
         rec_o.cls = CLS_STORE;
      end else begin
         rec_o.cls = CLS_ILLEGAL;
      end

      // Computed for every class; only meaningful when cls is CFG.
      case (insn_i[31:30])
         2'b10:   rec_o.cfg_type = CFG_VSETVL;
         2'b11:   rec_o.cfg_type = CFG_VSETIVLI;
         default: rec_o.cfg_type = CFG_VSETVLI;
      endcase
   end

endmodule

// File: rtl/vec_insn_decode_q.sv
// RVV instruction decoder: classifies each accepted instruction and queues the
// decoded record in a DEPTH-entry FIFO ahead of vector issue.
module vec_insn_decode_q
   import vec_decode_pkg::*;
#(
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INSN_WIDTH-1:0] insn_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            out_class,
   output logic [2:0]            out_funct3,
   output logic [4:0]            out_dest,
   output logic [4:0]            out_src_1,
   output logic [4:0]            out_src_2,
   output logic                  out_vm,
   output logic [5:0]            out_funct6,
   output logic [1:0]            out_mop,
   output logic                  out_mew,
   output logic [2:0]            out_nf,
   output logic [10:0]           out_zimm_11,
   output logic [9:0]            out_zimm_10,
   output logic [1:0]            out_cfg_type,
   output logic [CNT_WIDTH-1:0]  decode_cnt,
   output logic [CNT_WIDTH-1:0]  illegal_cnt
);

   if (INSN_WIDTH != 32) begin : g_bad_insn_width
      $error("vec_insn_decode_q: INSN_WIDTH must be 32");
   end
   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vec_insn_decode_q: DEPTH must be a power of two in 2..16");
   end

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CQ_W  = $clog2(DEPTH + 1);
   localparam logic [CQ_W-1:0] DEPTH_C = CQ_W'(DEPTH);

   vdec_rec_t             rec_dec;
   vdec_rec_t             head;
   vdec_rec_t             mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CQ_W-1:0]       count_q, count_d;
   logic [CNT_WIDTH-1:0]  dec_cnt_q, dec_cnt_d, ill_cnt_q, ill_cnt_d;
   logic                  push, pop;

   vec_insn_classify u_classify (
      .insn_i (insn_in),
      .rec_o  (rec_dec)
   );

   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      dec_cnt_d = dec_cnt_q;
      ill_cnt_d = ill_cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop) count_d = count_q + CQ_W'(1);
         if (pop && !push) count_d = count_q - CQ_W'(1);
      end
      // Counters saturate at all-ones instead of wrapping.
      if (push && dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_WIDTH'(1);
      if (push && rec_dec.cls == CLS_ILLEGAL && ill_cnt_q != '1)
         ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         dec_cnt_q <= '0;
         ill_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         dec_cnt_q <= dec_cnt_d;
         ill_cnt_q <= ill_cnt_d;
         if (push) mem_q[wr_ptr_q] <= rec_dec;
      end
   end

   assign head         = mem_q[rd_ptr_q];
   assign out_class    = head.cls;
   assign out_funct3   = head.funct3;
   assign out_dest     = head.dest;
   assign out_src_1    = head.src_1;
   assign out_src_2    = head.src_2;
   assign out_vm       = head.vm;
   assign out_funct6   = head.funct6;
   assign out_mop      = head.mop;
   assign out_mew      = head.mew;
   assign out_nf       = head.nf;
   assign out_zimm_11  = head.zimm_11;
   assign out_zimm_10  = head.zimm_10;
   assign out_cfg_type = head.cfg_type;
   assign decode_cnt   = dec_cnt_q;
   assign illegal_cnt  = ill_cnt_q;

endmodule
